// File: rtl/snoopy_axis_motion.sv
// Single-axis sprite motion controller: frame-gated signed velocity with
// accelerate/brake ramps, clamped position between MIN_POS and MAX_POS,
// wall-hit flags and a synchronous position load for respawn.
module snoopy_axis_motion #(
    parameter int POS_WIDTH   = 8,
    parameter int MIN_POS     = 0,
    parameter int MAX_POS     = 160,
    parameter int RESET_POS   = 0,
    parameter int SPEED_WIDTH = 5,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL       = 1,
    parameter int DECEL       = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          cmd_neg,
    input  logic                          cmd_pos,
    input  logic                          load_en,
    input  logic [POS_WIDTH-1:0]          load_pos,
    output logic [POS_WIDTH-1:0]          pos,
    output logic signed [SPEED_WIDTH-1:0] speed,
    output logic                          at_min,
    output logic                          at_max,
    output logic                          moving
);

    // Wide signed working width: position plus velocity can never overflow it,
    // so an excursion below MIN_POS shows up as a negative value, not a wrap.
    localparam int EW = POS_WIDTH + SPEED_WIDTH + 1;

    localparam logic signed [EW-1:0] MIN_W   = EW'(MIN_POS);
    localparam logic signed [EW-1:0] MAX_W   = EW'(MAX_POS);
    localparam logic signed [EW-1:0] VMAX_W  = EW'(MAX_SPEED);
    localparam logic signed [EW-1:0] ACC_W   = EW'(ACCEL);
    localparam logic signed [EW-1:0] DEC_W   = EW'(DECEL);

    localparam logic [POS_WIDTH-1:0] MIN_P   = POS_WIDTH'(MIN_POS);
    localparam logic [POS_WIDTH-1:0] MAX_P   = POS_WIDTH'(MAX_POS);
    localparam logic [POS_WIDTH-1:0] RESET_P = POS_WIDTH'(RESET_POS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POS,
        S_NEG,
        S_BRAKE
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_POS,
        DIR_NEG
    } dir_t;

    state_t state_q;
    state_t state_d;
    state_t tick_state;

    dir_t dir;

    logic signed [EW-1:0] speed_w;
    logic signed [EW-1:0] ramp_w;
    logic signed [EW-1:0] pos_w;
    logic signed [EW-1:0] sum_w;
    logic signed [EW-1:0] load_w;

    logic [POS_WIDTH-1:0]          pos_d;
    logic signed [SPEED_WIDTH-1:0] speed_d;
    logic [POS_WIDTH-1:0]          load_clamped;
    logic                          wall_hit;

    assign speed_w = EW'(speed);
    assign pos_w   = signed'({{(EW-POS_WIDTH){1'b0}}, pos});
    assign load_w  = signed'({{(EW-POS_WIDTH){1'b0}}, load_pos});

    // Decode the two buttons into one effective direction; both or neither is no command.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        dir = DIR_NONE;
        if (cmd_pos && !cmd_neg) begin
            dir = DIR_POS;
        end else if (cmd_neg && !cmd_pos) begin
            dir = DIR_NEG;
        end
    end

    // State the machine heads for on a tick, before the brake-to-idle decision.
    always_comb begin
        tick_state = state_q;
        unique case (dir)
            DIR_POS: tick_state = S_POS;
            DIR_NEG: tick_state = S_NEG;
            default: begin
                if (state_q != S_IDLE) begin
                    tick_state = S_BRAKE;
                end
            end
        endcase
    end

    // Velocity ramp from the pre-edge speed toward the target of tick_state.
    always_comb begin
        ramp_w = '0;
        unique case (tick_state)
            S_POS: begin
                ramp_w = speed_w + ACC_W;
                if (ramp_w > VMAX_W) begin
                    ramp_w = VMAX_W;
                end
            end
            S_NEG: begin
                ramp_w = speed_w - ACC_W;
                if (ramp_w < -VMAX_W) begin
                    ramp_w = -VMAX_W;
                end
            end
            S_BRAKE: begin
                if (speed_w > DEC_W) begin
                    ramp_w = speed_w - DEC_W;
                end else if (speed_w < -DEC_W) begin
                    ramp_w = speed_w + DEC_W;
                end else begin
                    ramp_w = '0;
                end
            end
            default: ramp_w = '0;
        endcase
    end

    // Position advances by the pre-edge speed; a wall clamps it and kills the velocity.
    always_comb begin
        sum_w    = pos_w + speed_w;
        pos_d    = sum_w[POS_WIDTH-1:0];
        speed_d  = ramp_w[SPEED_WIDTH-1:0];
        wall_hit = 1'b0;
        if (sum_w > MAX_W) begin
            pos_d    = MAX_P;
            wall_hit = 1'b1;
        end else if (sum_w < MIN_W) begin
            pos_d    = MIN_P;
            wall_hit = 1'b1;
        end
        if (wall_hit) begin
            speed_d = '0;
        end
    end

    // Respawn positions outside the bounds are pulled back onto the nearest bound.
    always_comb begin
        load_clamped = load_pos;
        if (load_w > MAX_W) begin
            load_clamped = MAX_P;
        end else if (load_w < MIN_W) begin
            load_clamped = MIN_P;
        end
    end

    // Next state: load forces idle; braking settles to idle once the ramp reaches zero.
    // The wall override does not enter this decision, so a wall hit while braking
    // reaches idle on the following tick.
    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = S_IDLE;
        end else if (tick) begin
            state_d = tick_state;
            if (state_q == S_BRAKE && tick_state == S_BRAKE && ramp_w == '0) begin
                state_d = S_IDLE;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Position and velocity registers: reset > load > tick > hold.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pos   <= RESET_P;
            speed <= '0;
        end else if (load_en) begin
            pos   <= load_clamped;
            speed <= '0;
        end else if (tick) begin
            pos   <= pos_d;
            speed <= speed_d;
        end
    end

    assign at_min = (pos == MIN_P);
    assign at_max = (pos == MAX_P);
    assign moving = (speed != '0);

endmodule

// File: tb/tb_snoopy_axis_motion.sv
// Directed bench for snoopy_axis_motion with hand-computed expectations
// (default parameters: bounds 0..160, max speed 4, accel/decel 1).
module tb_snoopy_axis_motion;

    logic              clock = 1'b0;
    logic              reset;
    logic              tick;
    logic              cmd_neg;
    logic              cmd_pos;
    logic              load_en;
    logic [7:0]        load_pos;
    logic [7:0]        pos;
    logic signed [4:0] speed;
    logic              at_min;
    logic              at_max;
    logic              moving;

    int total = 0;
    int bad   = 0;

    snoopy_axis_motion dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .cmd_neg  (cmd_neg),
        .cmd_pos  (cmd_pos),
        .load_en  (load_en),
        .load_pos (load_pos),
        .pos      (pos),
        .speed    (speed),
        .at_min   (at_min),
        .at_max   (at_max),
        .moving   (moving)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ps(input string tag, input int exp_pos, input int exp_speed);
        check({tag, ".pos"}, int'(pos), exp_pos);
        check({tag, ".speed"}, int'(speed), exp_speed);
    endtask

    int ramp_speed [6] = '{1, 2, 3, 4, 4, 4};
    int ramp_pos   [6] = '{0, 1, 3, 6, 10, 14};
    int brake_speed[5] = '{3, 2, 1, 0, 0};
    int brake_pos  [5] = '{18, 21, 23, 24, 24};
    int rwall_pos  [5] = '{158, 159, 160, 160, 160};
    int rwall_speed[5] = '{1, 2, 0, 1, 0};
    int lwall_speed[3] = '{-1, 0, -1};

    initial begin
        reset    = 1'b0;
        tick     = 1'b1;
        cmd_neg  = 1'b0;
        cmd_pos  = 1'b1;
        load_en  = 1'b0;
        load_pos = '0;

        // Reset held for two edges while commanding motion.
        step();
        step();
        check_ps("reset", 0, 0);
        check("reset.moving", int'(moving), 0);
        check("reset.at_min", int'(at_min), 1);

        // Ramp up with a tick-gated pause after the third tick.
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_ps($sformatf("ramp%0d", i + 1), ramp_pos[i], ramp_speed[i]);
            if (i == 2) begin
                tick = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    step();
                end
                check_ps("gate", 3, 3);
                check("gate.moving", int'(moving), 1);
                tick = 1'b1;
            end
        end

        // Release: brake to zero, then idle.
        cmd_pos = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_ps($sformatf("brake%0d", i + 1), brake_pos[i], brake_speed[i]);
            if (i == 3) begin
                check("brake.moving", int'(moving), 0);
            end
        end

        // Load with tick and command present: load wins.
        cmd_pos  = 1'b1;
        load_en  = 1'b1;
        load_pos = 8'd158;
        step();
        check_ps("load", 158, 0);
        load_en = 1'b0;

        // Right wall: pinned at 160, speed alternates 0 / 1.
        for (int i = 0; i < 5; i++) begin
            step();
            check_ps($sformatf("rwall%0d", i + 1), rwall_pos[i], rwall_speed[i]);
            if (i == 2) begin
                check("rwall.at_max", int'(at_max), 1);
            end
        end

        // Out-of-range load is clamped to MAX_POS.
        cmd_pos  = 1'b0;
        load_en  = 1'b1;
        load_pos = 8'd200;
        step();
        check_ps("clamp", 160, 0);

        // Left wall: no unsigned wrap below zero.
        load_pos = 8'd0;
        step();
        load_en = 1'b0;
        cmd_neg = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ps($sformatf("lwall%0d", i + 1), 0, lwall_speed[i]);
            check($sformatf("lwall%0d.at_min", i + 1), int'(at_min), 1);
        end

        // Conflicting commands at speed 3 brake.
        cmd_neg  = 1'b0;
        load_en  = 1'b1;
        load_pos = 8'd50;
        step();
        load_en = 1'b0;
        cmd_pos = 1'b1;
        step();
        step();
        step();
        check_ps("conf.pre", 53, 3);
        cmd_neg = 1'b1;
        step();
        check_ps("conf1", 56, 2);
        step();
        check_ps("conf2", 58, 1);

        // Reset in the middle of a ramp.
        cmd_neg = 1'b0;
        step();
        reset = 1'b0;
        step();
        check_ps("midreset", 0, 0);
        reset = 1'b1;
        step();
        check_ps("postreset", 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snoopy_axis_motion.md
Name: snoopy_axis_motion

Overview:
Parametrised single-axis motion controller for Snoopy and other sprites. It supersedes the fixed ±1-speed horizontal mover. Adds a frame-tick enable, signed velocity with acceleration/deceleration ramps, configurable signed-safe bounds with wall-hit flags, and a position-load port for respawn. One instance per axis, between the input-decode logic and the sprite renderer.

Parameters:
POS_WIDTH, 8, position register width (unsigned)
MIN_POS, 0, lower position bound (inclusive)
MAX_POS, 160, upper position bound (inclusive); MIN_POS <= MAX_POS < 2^POS_WIDTH
RESET_POS, 0, position after reset; MIN_POS <= RESET_POS <= MAX_POS
SPEED_WIDTH, 5, signed velocity width (two's complement)
MAX_SPEED, 4, velocity magnitude limit; 0 < MAX_SPEED < 2^(SPEED_WIDTH-1)
ACCEL, 1, velocity change per tick while a direction is held
DECEL, 1, velocity change per tick toward 0 while braking

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
tick  in  1  frame enable; motion updates only on cycles with tick=1
cmd_neg  in  1  move toward MIN_POS (left/up)
cmd_pos  in  1  move toward MAX_POS (right/down)
load_en  in  1  synchronous position load
load_pos  in  POS_WIDTH  value to load
pos  out  POS_WIDTH  current position (registered)
speed  out  SPEED_WIDTH  current signed velocity (registered)
at_min  out  1  pos == MIN_POS (combinational from pos)
at_max  out  1  pos == MAX_POS (combinational from pos)
moving  out  1  speed != 0

Behaviour:
- One clock; reset is synchronous and active-low. reset=0 at a clock edge: pos=RESET_POS, speed=0, state=S_IDLE, independent of tick. This also holds mid-motion.
- Priority per edge: reset > load_en > tick > hold.
- load_en=1: pos=clamp(load_pos), speed=0, state=S_IDLE. tick is ignored that cycle.
- tick=0 with no load/reset: all registers hold.
- Effective command: dir=POS if cmd_pos&!cmd_neg; NEG if cmd_neg&!cmd_pos; NONE if both or neither.
- States: S_IDLE, S_POS, S_NEG, S_BRAKE. Transitions happen on tick cycles only.
  - dir=POS -> S_POS from any state.
  - dir=NEG -> S_NEG from any state.
  - dir=NONE: S_POS/S_NEG -> S_BRAKE. S_BRAKE -> S_IDLE when the new speed is 0. S_IDLE stays.
- Velocity on tick, computed from the pre-edge speed s:
  - S_POS next: min(s+ACCEL, +MAX_SPEED).
  - S_NEG next: max(s-ACCEL, -MAX_SPEED).
  - Reversal passes through zero naturally (e.g. +3 -> +2 under NEG).
  - S_BRAKE next: s moves toward 0 by DECEL without overshoot.
  - S_IDLE next: 0.
- Position on tick uses the pre-edge speed s (one-tick velocity latency). Compute p = pos + s in POS_WIDTH+SPEED_WIDTH+1 signed bits:
  - p > MAX_POS: pos=MAX_POS, and speed is forced to 0 this edge, overriding the ramp.
  - p < MIN_POS: pos=MIN_POS, speed forced to 0.
  - otherwise pos=p.
  - No unsigned wrap is allowed: pos=0 with s=-1 must give pos=0, never 255.
- Holding into a wall alternates speed 0 / ±ACCEL, and pos stays pinned at the bound.
- State after a wall hit follows the normal command rules; the forced speed=0 does not itself change state. If the state is S_BRAKE, it moves to S_IDLE on the next tick.

Test Plan:
- Reset: reset=0 for 2 cycles with cmd_pos=1 and tick=1 -> pos=0, speed=0, moving=0, at_min=1.
- Ramp: from reset, hold cmd_pos, tick every cycle.
  - speed after ticks 1..5 = 1,2,3,4,4.
  - pos after ticks 1..6 = 0,1,3,6,10,14.
- Brake: at speed=4 and pos=14, release cmd_pos.
  - speed = 3,2,1,0.
  - pos = 18,21,23,24,24.
  - state reaches S_IDLE when speed hits 0; moving drops with it.
- Right wall: load_pos=158, load_en pulse, then hold cmd_pos with tick.
  - pos/speed = 158/1, 159/2, 160/0 (at_max=1), 160/1, 160/0.
- Left wall, no wrap: pos=0, hold cmd_neg -> pos/speed = 0/-1, 0/0; at_min=1 throughout; pos never 255.
- Gating and conflicts:
  - tick=0 for 10 cycles with cmd_pos=1 -> nothing changes.
  - At speed=3, assert cmd_pos&cmd_neg -> S_BRAKE, speed 2.
  - load_en and tick in the same cycle -> load wins.
  - reset mid-ramp -> pos=0, speed=0.
